// File: rtl/cache_refill_arbiter.sv
// cache_refill_arbiter
//   Shares one word-wide main-memory read port between the iCache (4-word
//   blocks) and the dCache (2-word blocks). One refill is handled at a time:
//   arbitrate in IDLE, fetch the block words in ascending order in BURST, and
//   present the last word together with the owner's done pulse in DONE.
//
//   Optional build macro: ARB_ROUND_ROBIN_EN
//     defined   - a tie in IDLE goes to the cache that was not served last
//     undefined - a tie in IDLE always goes to the dCache
module cache_refill_arbiter #(
  parameter int IBLK_WORDS = 4,
  parameter int DBLK_WORDS = 2
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  output logic        i_gnt,
  output logic        d_gnt,
  output logic        i_fill_valid,
  output logic        d_fill_valid,
  output logic [1:0]  fill_idx,
  output logic [31:0] fill_data,
  output logic        i_done,
  output logic        d_done,
  output logic        busy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Index of the final word of each block type.
  localparam logic [1:0] I_LAST = 2'(IBLK_WORDS - 1);
  localparam logic [1:0] D_LAST = 2'(DBLK_WORDS - 1);

  // Block-alignment masks: clear the byte offset within a block.
  localparam logic [31:0] I_MASK = ~(32'(IBLK_WORDS * 4) - 32'd1);
  localparam logic [31:0] D_MASK = ~(32'(DBLK_WORDS * 4) - 32'd1);

  logic [1:0]  state_r;
  logic        owner_d_r;     // 1: dCache owns the transaction, 0: iCache
  logic [31:0] base_r;
  logic [1:0]  last_r;
  logic [1:0]  cnt_r;
  logic        mem_req_r;
  logic [31:0] mem_addr_r;
  logic [31:0] fill_data_r;
  logic [1:0]  fill_idx_r;
  logic        i_fv_r;
  logic        d_fv_r;
  logic        i_done_r;
  logic        d_done_r;
  logic        i_gnt_r;
  logic        d_gnt_r;
  logic        busy_r;
`ifdef ARB_ROUND_ROBIN_EN
  logic        last_d_r;      // 1: dCache was served last, 0: iCache
`endif

  logic        pick_d_s;
  logic [31:0] new_base_s;
  logic [1:0]  cnt_nxt_s;

  // Arbitration: choose the winner among the requests visible in IDLE.
  always_comb begin
    pick_d_s = 1'b0;
    if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      pick_d_s = ~last_d_r;
`else
      pick_d_s = 1'b1;
`endif
    end else if (d_req) begin
      pick_d_s = 1'b1;
    end else begin
      pick_d_s = 1'b0;
    end
  end

  // Block base of the winning request and the next word counter value.
  always_comb begin
    new_base_s = 32'd0;
    cnt_nxt_s  = cnt_r + 2'd1;
    if (pick_d_s) begin
      new_base_s = d_addr & D_MASK;
    end else begin
      new_base_s = i_addr & I_MASK;
    end
  end

  // Refill sequencer: arbitration, word fetch loop and fill/done generation.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_r     <= S_IDLE;
      owner_d_r   <= 1'b0;
      base_r      <= 32'd0;
      last_r      <= 2'd0;
      cnt_r       <= 2'd0;
      mem_req_r   <= 1'b0;
      mem_addr_r  <= 32'd0;
      fill_data_r <= 32'd0;
      fill_idx_r  <= 2'd0;
      i_fv_r      <= 1'b0;
      d_fv_r      <= 1'b0;
      i_done_r    <= 1'b0;
      d_done_r    <= 1'b0;
      i_gnt_r     <= 1'b0;
      d_gnt_r     <= 1'b0;
      busy_r      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_r    <= 1'b0;
`endif
    end else begin
      // Fill and done strobes are single-cycle unless re-asserted below.
      i_fv_r   <= 1'b0;
      d_fv_r   <= 1'b0;
      i_done_r <= 1'b0;
      d_done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (i_req || d_req) begin
            state_r    <= S_BURST;
            owner_d_r  <= pick_d_s;
            base_r     <= new_base_s;
            last_r     <= pick_d_s ? D_LAST : I_LAST;
            cnt_r      <= 2'd0;
            mem_req_r  <= 1'b1;
            mem_addr_r <= new_base_s;
            i_gnt_r    <= ~pick_d_s;
            d_gnt_r    <= pick_d_s;
            busy_r     <= 1'b1;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_BURST: begin
          if (mem_ack) begin
            fill_data_r <= mem_rdata;
            fill_idx_r  <= cnt_r;
            i_fv_r      <= ~owner_d_r;
            d_fv_r      <= owner_d_r;
            if (cnt_r == last_r) begin
              // Final word: its fill is presented together with done.
              state_r   <= S_DONE;
              mem_req_r <= 1'b0;
              i_done_r  <= ~owner_d_r;
              d_done_r  <= owner_d_r;
`ifdef ARB_ROUND_ROBIN_EN
              last_d_r  <= owner_d_r;
`endif
            end else begin
              // Keep mem_req high and step to the next word address.
              cnt_r      <= cnt_nxt_s;
              mem_addr_r <= base_r + {28'd0, cnt_nxt_s, 2'b00};
            end
          end else begin
            state_r <= S_BURST;
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
          i_gnt_r <= 1'b0;
          d_gnt_r <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r   <= S_IDLE;
          mem_req_r <= 1'b0;
          i_gnt_r   <= 1'b0;
          d_gnt_r   <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign i_gnt        = i_gnt_r;
  assign d_gnt        = d_gnt_r;
  assign i_fill_valid = i_fv_r;
  assign d_fill_valid = d_fv_r;
  assign fill_idx     = fill_idx_r;
  assign fill_data    = fill_data_r;
  assign i_done       = i_done_r;
  assign d_done       = d_done_r;
  assign busy         = busy_r;
  assign mem_req      = mem_req_r;
  assign mem_addr     = mem_addr_r;

endmodule
